lsu_mem_master: RTL

- Load/store initiator driving the 64-bit memory port (ce/we/addr/wdata/wmask/rdata) of the DPI-backed memory model.
- Sits between EX and WB:
  - accepts one RV64 load/store per valid/ready handshake;
  - aligns data into byte lanes and generates the write mask;
  - holds the access for MEM_LAT cycles;
  - extracts and sign/zero-extends load data;
  - returns the result through a valid/ready response channel.

---
 rtl/lsu_mem_master_pkg.sv | 55 +++++
 rtl/lsu_mem_master_load_align.sv | 39 +++
 rtl/lsu_mem_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store memory master: RV64 funct3 encodings,
// the position of the store flag in the 4-bit op, the FSM state enum and
// helpers that decode size, legality and alignment from an op.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    localparam int LSU_STORE_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size, before lane shift.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        logic [7:0] m;
        case (funct3)
            LSU_B, LSU_BU: m = 8'h01;
            LSU_H, LSU_HU: m = 8'h03;
            LSU_W, LSU_WU: m = 8'h0F;
            LSU_D:         m = 8'hFF;
            default:       m = 8'h00;
        endcase
        return m;
    endfunction

    // Stores have no unsigned variants, and funct3=111 is unused for both.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op[2:0] == 3'b111) || (op[LSU_STORE_BIT] && op[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] offset);
        logic bad;
        case (funct3)
            LSU_H, LSU_HU: bad = offset[0];
            LSU_W, LSU_WU: bad = |offset[1:0];
            LSU_D:         bad = |offset;
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction: shifts the 8-byte-aligned read word
// down by the byte offset, keeps 8/16/32/64 bits and sign- or zero-extends.
//
// Ports:
//   i_word    64  aligned word read from memory
//   i_offset   3  byte offset of the access within the word
//   i_funct3   3  RISC-V load funct3
//   o_data    64  extended load result (0 for an unused funct3)
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_word,
    input  logic [2:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    logic [63:0] w_shifted;

    assign w_shifted = i_word >> {i_offset, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_funct3)
            LSU_B:  o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            LSU_H:  o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            LSU_W:  o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            LSU_D:  o_data = w_shifted;
            LSU_BU: o_data = {56'd0, w_shifted[7:0]};
            LSU_HU: o_data = {48'd0, w_shifted[15:0]};
            LSU_WU: o_data = {32'd0, w_shifted[31:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between EX and WB. Accepts one RV64 load/store per
// request handshake, drives the 64-bit memory port for MEM_LAT cycles,
// extracts load data and returns it on a valid/ready response channel.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; bad requests jump straight to RESP
// ACCESS| memory port driven, counting MEM_LAT cycles
// RESP  | response held until the consumer takes it
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_op                  [3]=store, [2:0]=funct3
//   i_req_addr, i_req_wdata   byte address, right-aligned store data
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_rdata, o_resp_err  extended load data, error flag
//   o_mem_*                   memory port (ce/we/addr/wdata/wmask)
//   i_mem_rdata               aligned read word
//
// MEM_LAT must be within 1..15 (4-bit cycle counter).
// -----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_op,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_ce,
    output logic        o_mem_we,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_wdata,
    output logic [7:0]  o_mem_wmask,
    input  logic [63:0] i_mem_rdata
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;

    logic [3:0]  r_op;
    logic [63:0] r_addr;
    logic [63:0] r_lane_wdata;
    logic [7:0]  r_lane_wmask;
    logic [3:0]  r_cnt;
    logic [63:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_req_bad;
    logic        w_req_store;
    logic        w_last;
    logic        w_is_store;
    logic [63:0] w_load_data;

    assign w_req_store = i_req_op[LSU_STORE_BIT];
    assign w_req_bad   = is_illegal(i_req_op) ||
                         is_misaligned(i_req_op[2:0], i_req_addr[2:0]);
    assign w_accept    = (r_state == ST_IDLE) && i_req_valid;
    assign w_last      = (r_cnt == CNT_LAST);
    assign w_is_store  = r_op[LSU_STORE_BIT];

    lsu_load_align u_load_align (
        .i_word   (i_mem_rdata),
        .i_offset (r_addr[2:0]),
        .i_funct3 (r_op[2:0]),
        .o_data   (w_load_data)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_next_state = w_req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: the memory port is fully gated outside ACCESS so it idles at 0.
    always_comb begin
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_ce     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wmask  = '0;
        case (r_state)
            ST_IDLE: o_req_ready = 1'b1;
            ST_ACCESS: begin
                o_mem_ce    = 1'b1;
                o_mem_we    = w_is_store;
                o_mem_addr  = {r_addr[63:3], 3'b000};
                o_mem_wdata = r_lane_wdata;
                o_mem_wmask = r_lane_wmask;
            end
            ST_RESP: o_resp_valid = 1'b1;
            default: o_req_ready = 1'b0;
        endcase
    end

    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    // Request latch, access counter and response capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op         <= '0;
            r_addr       <= '0;
            r_lane_wdata <= '0;
            r_lane_wmask <= '0;
            r_cnt        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= i_req_op;
                        r_addr <= i_req_addr;
                        r_cnt  <= '0;
                        // Lane data/mask are built once here so the port is
                        // stable for every ACCESS cycle; loads present zeros.
                        if (w_req_store && !w_req_bad) begin
                            r_lane_wdata <= i_req_wdata << {i_req_addr[2:0], 3'b000};
                            r_lane_wmask <= size_mask(i_req_op[2:0]) << i_req_addr[2:0];
                        end else begin
                            r_lane_wdata <= '0;
                            r_lane_wmask <= '0;
                        end
                        r_resp_err <= w_req_bad;
                        if (w_req_bad) begin
                            r_resp_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_resp_rdata <= w_is_store ? 64'd0 : w_load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
